// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter for instruction and data requests.
// Ports: CLK/nRST; imem* / dmem* request side; ram* RAM side; ihit/dhit
// completion pulses; err sticky timeout. Optional MEM_ARB_STARVE_EN
// enables the instruction anti-starvation grant.
module mem_arbiter #(
  parameter int TIMEOUT    = 15,
  parameter int STARVE_MAX = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        ramready,
  input  logic [31:0] ramload,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        err
);

  localparam int AW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  typedef enum logic [1:0] {
    IDLE, IACC, DACC, DONE
  } state_t;

  state_t state, state_n;

  logic [AW-1:0] acc_cnt, acc_cnt_n;
  logic        ihit_n, dhit_n;
  logic        ramREN_n, ramWEN_n;
  logic [31:0] ramaddr_n, ramstore_n;
  logic [31:0] imemload_n, dmemload_n;
  logic        err_n;

  logic dreq;
  logic grant_d, grant_i;
  logic starve_i;
  logic acc_end;
  logic [31:0] rd_val;

`ifdef MEM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt, starve_cnt_n;

  assign starve_i = imemREN &&
    (starve_cnt == SW'(STARVE_MAX));

  // Counts data grants taken while an I fetch waits.
  always_comb begin
    starve_cnt_n = starve_cnt;
    if (state == IDLE) begin
      if (grant_i || !imemREN)
        starve_cnt_n = '0;
      else if (grant_d &&
               starve_cnt != SW'(STARVE_MAX))
        starve_cnt_n = starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) starve_cnt <= '0;
    else       starve_cnt <= starve_cnt_n;
  end
`else
  assign starve_i = 1'b0;
`endif

  assign dreq    = dmemREN | dmemWEN;
  assign grant_d = (state == IDLE) && dreq && !starve_i;
  assign grant_i = (state == IDLE) && imemREN && !grant_d;

  // Access ends on RAM ack or on timeout; ack takes precedence.
  assign acc_end = ramready || (acc_cnt == AW'(TIMEOUT));
  assign rd_val  = ramready ? ramload : BAD;

  always_comb begin
    state_n    = state;
    acc_cnt_n  = acc_cnt;
    ihit_n     = 1'b0;
    dhit_n     = 1'b0;
    ramREN_n   = ramREN;
    ramWEN_n   = ramWEN;
    ramaddr_n  = ramaddr;
    ramstore_n = ramstore;
    imemload_n = imemload;
    dmemload_n = dmemload;
    err_n      = err;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_n    = DACC;
          acc_cnt_n  = '0;
          ramWEN_n   = dmemWEN;
          ramREN_n   = !dmemWEN;
          ramaddr_n  = dmemaddr;
          ramstore_n = dmemstore;
        end else if (grant_i) begin
          state_n   = IACC;
          acc_cnt_n = '0;
          ramREN_n  = 1'b1;
          ramWEN_n  = 1'b0;
          ramaddr_n = imemaddr;
        end
      end
      IACC, DACC: begin
        if (acc_end) begin
          state_n  = DONE;
          ramREN_n = 1'b0;
          ramWEN_n = 1'b0;
          if (!ramready) err_n = 1'b1;
          if (state == IACC) begin
            ihit_n     = 1'b1;
            imemload_n = rd_val;
          end else begin
            dhit_n = 1'b1;
            if (!ramWEN) dmemload_n = rd_val;
          end
        end else begin
          acc_cnt_n = acc_cnt + AW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      acc_cnt  <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      imemload <= '0;
      dmemload <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      acc_cnt  <= acc_cnt_n;
      ihit     <= ihit_n;
      dhit     <= dhit_n;
      ramREN   <= ramREN_n;
      ramWEN   <= ramWEN_n;
      ramaddr  <= ramaddr_n;
      ramstore <= ramstore_n;
      imemload <= imemload_n;
      dmemload <= dmemload_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector bench for mem_arbiter.
// Table of single transactions plus reset, contention, starvation, timeout.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN, dmemREN, dmemWEN;
  logic [31:0] imemaddr, dmemaddr, dmemstore;
  logic        ramready;
  logic [31:0] ramload;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ramready(ramready), .ramload(ramload),
    .ihit(ihit), .imemload(imemload),
    .dhit(dhit), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ia, da, st, ld;
    int          lat;
    logic        ei, ew;
    logic [31:0] ea, es, eil, edl;
  } vec_t;

  vec_t vt[6];

  function automatic vec_t mk(
    input logic ir, dr, dw,
    input logic [31:0] ia, da, st, ld,
    input int lat,
    input logic ei, ew,
    input logic [31:0] ea, es, eil, edl);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw;
    v.ia = ia; v.da = da; v.st = st;
    v.ld = ld; v.lat = lat;
    v.ei = ei; v.ew = ew;
    v.ea = ea; v.es = es;
    v.eil = eil; v.edl = edl;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic wait_strobe(input int budget,
                             output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (ramREN || ramWEN) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL strobe_wait: got none expected strobe in %0d",
               budget);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ihit"}, 32'(ihit), 0);
    chk({tag, "_dhit"}, 32'(dhit), 0);
    chk({tag, "_ramREN"}, 32'(ramREN), 0);
    chk({tag, "_ramWEN"}, 32'(ramWEN), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_ramaddr"}, ramaddr, 0);
    chk({tag, "_ramstore"}, ramstore, 0);
    chk({tag, "_imemload"}, imemload, 0);
    chk({tag, "_dmemload"}, dmemload, 0);
  endtask

  task automatic drop_all();
    imemREN = 0; dmemREN = 0; dmemWEN = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int n;
    logic gi, gd;
    logic exp_si[5];

    vt[0] = mk(1, 0, 0, 32'h40, 0, 0,
               32'h8C220004, 2, 1, 0, 32'h40, 0,
               32'h8C220004, 0);
    vt[1] = mk(0, 1, 0, 0, 32'h200, 0,
               32'h12345678, 0, 0, 0, 32'h200, 0,
               32'h8C220004, 32'h12345678);
    vt[2] = mk(0, 0, 1, 0, 32'h100, 32'hDEADBEEF,
               32'h55555555, 1, 0, 1, 32'h100,
               32'hDEADBEEF, 32'h8C220004, 32'h12345678);
    vt[3] = mk(0, 1, 1, 0, 32'h104, 32'hCAFEF00D,
               32'h66666666, 0, 0, 1, 32'h104,
               32'hCAFEF00D, 32'h8C220004, 32'h12345678);
    vt[4] = mk(1, 0, 0, 32'h44, 0, 0,
               32'h00000013, 3, 1, 0, 32'h44, 0,
               32'h00000013, 32'h12345678);
    vt[5] = mk(0, 1, 0, 0, 32'hFFFFFFFC, 0,
               32'hA5A5A5A5, 0, 0, 0, 32'hFFFFFFFC, 0,
               32'h00000013, 32'hA5A5A5A5);

`ifdef MEM_ARB_STARVE_EN
    exp_si = '{0, 0, 0, 1, 0};
`else
    exp_si = '{0, 0, 0, 0, 0};
`endif

    nRST = 0;
    drop_all();
    imemaddr = 0; dmemaddr = 0; dmemstore = 0;
    ramready = 0; ramload = 0;
    repeat (2) @(negedge CLK);
    chk_reset_outs("rst");
    nRST = 1;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) begin
      imemREN = vt[i].ir; imemaddr = vt[i].ia;
      dmemREN = vt[i].dr; dmemWEN = vt[i].dw;
      dmemaddr = vt[i].da; dmemstore = vt[i].st;
      wait_strobe(4, seen);
      if (seen) begin
        chk($sformatf("v%0d_addr", i), ramaddr, vt[i].ea);
        chk($sformatf("v%0d_wen", i), 32'(ramWEN),
            32'(vt[i].ew));
        chk($sformatf("v%0d_ren", i), 32'(ramREN),
            32'(!vt[i].ew));
        if (vt[i].ew)
          chk($sformatf("v%0d_store", i), ramstore, vt[i].es);
        for (int k = 0; k < vt[i].lat; k++) begin
          imemaddr = ~vt[i].ia;
          dmemaddr = ~vt[i].da;
          dmemstore = ~vt[i].st;
          @(negedge CLK);
          chk($sformatf("v%0d_hold%0d", i, k),
              ramaddr, vt[i].ea);
          chk($sformatf("v%0d_strb%0d", i, k),
              32'(ramREN | ramWEN), 1);
        end
        ramready = 1; ramload = vt[i].ld;
        @(negedge CLK);
        ramready = 0;
        chk($sformatf("v%0d_ihit", i), 32'(ihit),
            32'(vt[i].ei));
        chk($sformatf("v%0d_dhit", i), 32'(dhit),
            32'(!vt[i].ei));
        chk($sformatf("v%0d_strbdn", i),
            32'(ramREN | ramWEN), 0);
        chk($sformatf("v%0d_iload", i), imemload, vt[i].eil);
        chk($sformatf("v%0d_dload", i), dmemload, vt[i].edl);
      end
      drop_all();
      @(negedge CLK);
      chk($sformatf("v%0d_hitclr", i), 32'(ihit | dhit), 0);
    end

    // reset in the middle of a data access
    dmemREN = 1; dmemaddr = 32'h500;
    wait_strobe(4, seen);
    nRST = 0; drop_all();
    repeat (2) @(negedge CLK);
    chk_reset_outs("rstmid");
    nRST = 1;
    n = 0;
    repeat (4) begin
      @(negedge CLK);
      if (ihit || dhit || ramREN || ramWEN) n++;
    end
    chk("rstmid_quiet", 32'(n), 0);

    // contention: write first, then the fetch
    imemREN = 1; imemaddr = 32'h80;
    dmemWEN = 1; dmemaddr = 32'h100;
    dmemstore = 32'hDEADBEEF;
    wait_strobe(4, seen);
    chk("cont_wen", 32'(ramWEN), 1);
    chk("cont_ren", 32'(ramREN), 0);
    chk("cont_addr", ramaddr, 32'h100);
    chk("cont_store", ramstore, 32'hDEADBEEF);
    ramready = 1; ramload = 0;
    @(negedge CLK);
    ramready = 0;
    chk("cont_dhit", 32'(dhit), 1);
    chk("cont_ihit0", 32'(ihit), 0);
    dmemWEN = 0;
    wait_strobe(4, seen);
    chk("cont_iren", 32'(ramREN), 1);
    chk("cont_iaddr", ramaddr, 32'h80);
    ramready = 1; ramload = 32'h11112222;
    @(negedge CLK);
    ramready = 0;
    chk("cont_ihit", 32'(ihit), 1);
    chk("cont_iload", imemload, 32'h11112222);
    drop_all();
    @(negedge CLK);

    // ramready while idle is ignored
    ramready = 1; ramload = 32'hFFFFFFFF;
    @(negedge CLK);
    ramready = 0;
    chk("idle_rdy_hit", 32'(ihit | dhit), 0);
    chk("idle_rdy_iload", imemload, 32'h11112222);

    // starvation: fetch held against back-to-back data
    imemREN = 1; imemaddr = 32'h90;
    dmemREN = 1; dmemaddr = 32'h300;
    for (int k = 0; k < 5; k++) begin
      wait_strobe(6, seen);
      ramready = 1; ramload = 32'(k);
      @(negedge CLK);
      ramready = 0;
      gi = ihit; gd = dhit;
      chk($sformatf("starve%0d_ihit", k), 32'(gi),
          32'(exp_si[k]));
      chk($sformatf("starve%0d_dhit", k), 32'(gd),
          32'(!exp_si[k]));
      if (gi) imemREN = 0;
    end
    drop_all();
    @(negedge CLK);

    // timeout on a data read
    chk("pre_to_err", 32'(err), 0);
    dmemREN = 1; dmemaddr = 32'h400;
    wait_strobe(4, seen);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      n++;
      if (dhit) break;
    end
    chk("to_cycles", 32'(n), 16);
    chk("to_dhit", 32'(dhit), 1);
    chk("to_dload", dmemload, 32'hBAD1BAD1);
    chk("to_err", 32'(err), 1);
    drop_all();
    repeat (3) @(negedge CLK);
    chk("to_err_sticky", 32'(err), 1);
    nRST = 0;
    repeat (2) @(negedge CLK);
    chk("to_err_rst", 32'(err), 0);
    nRST = 1;
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
